// File: rtl/cr_wb_queue.sv
// cr_wb_queue: in-order, field-masked write-back queue that sits in front of the
// condition register. It buffers CR updates, retires at most one per cycle and
// presents a forwarded CR view (committed value merged with all pending updates).
// Optional build macro CR_WB_BYPASS_EN: an update arriving while the queue is
// empty and retire is permitted goes straight to CR in the same cycle.
module cr_wb_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CR_WIDTH-1:0]         in_data,
    input  logic [7:0]                  in_fmask,
    input  logic                        retire_en,
    input  logic                        flush,
    input  logic [CR_WIDTH-1:0]         cr_q,
    output logic                        cr_wr,
    output logic [CR_WIDTH-1:0]         cr_wd,
    output logic [CR_WIDTH-1:0]         fwd_cr,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned NFIELD  = 8;
    localparam int unsigned FIELD_W = CR_WIDTH / NFIELD;

    logic [CR_WIDTH-1:0] data_q  [DEPTH];
    logic [NFIELD-1:0]   fmask_q [DEPTH];
    logic [PTR_W-1:0]    head_q;
    logic [PTR_W-1:0]    tail_q;
    logic [CNT_W-1:0]    count_q;

    logic                push_c;
    logic                retire_c;
    logic                bypass_c;
    logic [CR_WIDTH-1:0] fwd_acc_c;

    // Expand an 8-bit field mask to a per-bit CR mask.
    function automatic logic [CR_WIDTH-1:0] expand(input logic [NFIELD-1:0] m);
        logic [CR_WIDTH-1:0] e;
        e = '0;
        for (int i = 0; i < int'(NFIELD); i++) begin
            e[i*FIELD_W +: FIELD_W] = {FIELD_W{m[i]}};
        end
        return e;
    endfunction

    // Replace the masked fields of base with the corresponding fields of upd.
    function automatic logic [CR_WIDTH-1:0] merge(input logic [CR_WIDTH-1:0] base,
                                                  input logic [CR_WIDTH-1:0] upd,
                                                  input logic [NFIELD-1:0]   m);
        logic [CR_WIDTH-1:0] e;
        e = expand(m);
        return (base & ~e) | (upd & e);
    endfunction

    // Handshake, retire and bypass decisions; reset and flush suppress all activity.
    always_comb begin
        in_ready = rst || (count_q < CNT_W'(DEPTH));
        retire_c = !rst && (count_q != '0) && retire_en && !flush;
`ifdef CR_WB_BYPASS_EN
        bypass_c = !rst && (count_q == '0) && retire_en && !flush && in_valid && (in_fmask != '0);
`else
        bypass_c = 1'b0;
`endif
        // An all-zero mask is accepted but changes nothing, so it is never stored.
        push_c   = !rst && in_valid && in_ready && !flush && (in_fmask != '0) && !bypass_c;
    end

    // CR write port: oldest entry when retiring, the live request when bypassing.
    always_comb begin
        cr_wr = 1'b0;
        cr_wd = cr_q;
        if (retire_c) begin
            cr_wr = 1'b1;
            cr_wd = merge(cr_q, data_q[head_q], fmask_q[head_q]);
        end else if (bypass_c) begin
            cr_wr = 1'b1;
            cr_wd = merge(cr_q, in_data, in_fmask);
        end
    end

    // Forwarded view: committed CR overlaid with pending entries, oldest first.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_acc_c = cr_q;
        idx       = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = PTR_W'(head_q + PTR_W'(k));
            if (CNT_W'(k) < count_q) begin
                fwd_acc_c = merge(fwd_acc_c, data_q[idx], fmask_q[idx]);
            end
        end
        fwd_cr = rst ? cr_q : fwd_acc_c;
        count  = rst ? '0 : count_q;
    end

    // Circular buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= '0;
                fmask_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            if (push_c) begin
                data_q[tail_q]  <= in_data;
                fmask_q[tail_q] <= in_fmask;
                tail_q          <= PTR_W'(tail_q + PTR_W'(1));
            end
            if (retire_c) begin
                head_q <= PTR_W'(head_q + PTR_W'(1));
            end
            if (push_c && !retire_c) begin
                count_q <= CNT_W'(count_q + CNT_W'(1));
            end else if (!push_c && retire_c) begin
                count_q <= CNT_W'(count_q - CNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_cr_wb_queue.sv
// Testbench for cr_wb_queue: directed scenarios followed by random traffic, with
// expectations produced by a queue-based reference model and checked by a
// separate monitor. Honours CR_WB_BYPASS_EN when the build defines it.
module tb_cr_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CRW   = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CRW-1:0]   in_data;
    logic [7:0]       in_fmask;
    logic             retire_en;
    logic             flush;
    logic [CRW-1:0]   cr_q;
    logic             cr_wr;
    logic [CRW-1:0]   cr_wd;
    logic [CRW-1:0]   fwd_cr;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    cr_wb_queue #(.DEPTH(DEPTH), .CR_WIDTH(CRW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_fmask  (in_fmask),
        .retire_en (retire_en),
        .flush     (flush),
        .cr_q      (cr_q),
        .cr_wr     (cr_wr),
        .cr_wd     (cr_wd),
        .fwd_cr    (fwd_cr),
        .count     (count)
    );

    typedef struct {
        int unsigned    idx;
        logic           rdy;
        logic           wr;
        logic [CRW-1:0] wd;
        logic [CRW-1:0] fwd;
        int unsigned    cnt;
    } cyc_t;

    typedef struct {
        int unsigned    idx;
        logic [CRW-1:0] wd;
    } wr_t;

    cyc_t           cyc_q[$];
    wr_t            wr_q[$];
    logic [CRW-1:0] pend_d[$];
    logic [7:0]     pend_m[$];
    logic [CRW-1:0] model_cr;
    int unsigned    cyc_n;
    int             n_cmp;
    int             n_bad;

    // Reference merge: take field i from upd wherever mask bit i is set.
    function automatic logic [CRW-1:0] ref_merge(input logic [CRW-1:0] base,
                                                 input logic [CRW-1:0] upd,
                                                 input logic [7:0]     m);
        logic [CRW-1:0] r;
        r = base;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[4*i +: 4] = upd[4*i +: 4];
        end
        return r;
    endfunction

    task automatic chk(input string name, input int unsigned idx,
                       input logic [CRW-1:0] act, input logic [CRW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle, record expectations, then advance the model.
    task automatic step(input logic r, input logic v, input logic re, input logic fl,
                        input logic [CRW-1:0] d, input logic [7:0] m);
        cyc_t e;
        wr_t  w;
        int   n;
        logic ready, retire, bypass;
        rst       = r;
        in_valid  = v;
        retire_en = re;
        flush     = fl;
        in_data   = d;
        in_fmask  = m;
        cr_q      = model_cr;
        n         = pend_d.size();
        e.idx     = cyc_n;
        if (r) begin
            e.rdy = 1'b1;
            e.wr  = 1'b0;
            e.wd  = model_cr;
            e.fwd = model_cr;
            e.cnt = 0;
            cyc_q.push_back(e);
            pend_d.delete();
            pend_m.delete();
        end else begin
            ready  = (n < int'(DEPTH));
            retire = (n > 0) && re && !fl;
            bypass = 1'b0;
`ifdef CR_WB_BYPASS_EN
            bypass = (n == 0) && re && !fl && v && (m != 8'h00);
`endif
            e.rdy = ready;
            e.wr  = retire || bypass;
            if (retire)      e.wd = ref_merge(model_cr, pend_d[0], pend_m[0]);
            else if (bypass) e.wd = ref_merge(model_cr, d, m);
            else             e.wd = model_cr;
            e.fwd = model_cr;
            foreach (pend_d[i]) e.fwd = ref_merge(e.fwd, pend_d[i], pend_m[i]);
            e.cnt = n;
            cyc_q.push_back(e);
            if (e.wr) begin
                w.idx = cyc_n;
                w.wd  = e.wd;
                wr_q.push_back(w);
            end
            if (fl) begin
                pend_d.delete();
                pend_m.delete();
            end else begin
                if (e.wr) model_cr = e.wd;
                if (retire) begin
                    void'(pend_d.pop_front());
                    void'(pend_m.pop_front());
                end
                if (v && ready && (m != 8'h00) && !bypass) begin
                    pend_d.push_back(d);
                    pend_m.push_back(m);
                end
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic re, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, re, 1'b0, 32'h0, 8'h00);
    endtask

    // Monitor: per-cycle output checks plus in-order matching of CR writes.
    always @(negedge clk) begin
        cyc_t e;
        wr_t  w;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("in_ready", e.idx, 32'(in_ready), 32'(e.rdy));
            chk("cr_wr",    e.idx, 32'(cr_wr),    32'(e.wr));
            chk("cr_wd",    e.idx, cr_wd,         e.wd);
            chk("fwd_cr",   e.idx, fwd_cr,        e.fwd);
            chk("count",    e.idx, 32'(count),    e.cnt);
            if (cr_wr === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr", e.idx, 32'd1, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_cycle", e.idx, 32'(e.idx), 32'(w.idx));
                    chk("wr_data",  e.idx, cr_wd,      w.wd);
                end
            end
        end
    end

    initial begin
        logic [7:0] m;
        n_cmp     = 0;
        n_bad     = 0;
        cyc_n     = 0;
        model_cr  = 32'h0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        retire_en = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_fmask  = '0;
        cr_q      = '0;
        @(posedge clk);
        #1;

        // Reset.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'hFF);

        // Single push then retire.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 8'h80);
        idle(1'b1, 2);

        // Two overlapping updates held, then drained in order.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 8'h80);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 8'h80);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Fill to DEPTH, attempt a fifth, then drain.
        for (int i = 0; i < int'(DEPTH) + 1; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 8'(1 << i));
        idle(1'b0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 8'hFF);
        idle(1'b1, int'(DEPTH) + 2);

        // Flush with a concurrent request.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA, 8'h0F);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h5555_5555, 8'hF0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 8'hFF);
        idle(1'b1, 2);

        // Zero field mask.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'h00);
        idle(1'b1, 1);

        // Empty queue, low field update (same cycle when bypass is built in).
        model_cr = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_000A, 8'h01);
        idle(1'b1, 2);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(49) == 0) model_cr = $urandom;
            m = 8'($urandom);
            if ($urandom_range(7) == 0) m = 8'h00;
            step(1'($urandom_range(199) == 0), 1'($urandom_range(2) != 0),
                 1'($urandom_range(3) != 0), 1'($urandom_range(31) == 0),
                 $urandom, m);
        end
        idle(1'b1, int'(DEPTH) + 2);

        chk("writes_drained", cyc_n, 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
